// File: rtl/intc_apb_master.sv
// intc_apb_master: single-outstanding request/ack front end to an APB3/APB4
// requester. Converts each accepted request into one SETUP + ACCESS transfer,
// honours pready wait states and reports pslverr with a one-cycle ack strobe.
// Optional feature macro: APB_MST_TIMEOUT_EN bounds the ACCESS wait with an
// 8-bit counter and terminates a stuck transfer with an error ack.
module intc_apb_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic          req_wr_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [3:0]    req_strb_i,
    input  logic [2:0]    req_prot_i,
    output logic          busy_o,
    output logic          ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          err_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o,
    output logic [3:0]    pstrb_o,
    output logic [2:0]    pprot_o,
    input  logic [DW-1:0] prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_r;

`ifdef APB_MST_TIMEOUT_EN
    // Last wait count before the limit: a pready=0 cycle seen at this count
    // is the TO_CYC-th wait state and ends the transfer.
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
    logic [7:0] wait_cnt_r;

    // Wait-state counter: cleared on SETUP entry, counts ACCESS cycles without pready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r == ST_IDLE) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_ACCESS) && !pready_i) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`endif

    // Transfer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            busy_o    <= 1'b0;
            ack_o     <= 1'b0;
            rdata_o   <= {DW{1'b0}};
            err_o     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= {AW{1'b0}};
            pwdata_o  <= {DW{1'b0}};
            pstrb_o   <= 4'b0000;
            pprot_o   <= 3'b000;
        end else begin
            // ack is a strobe; only the completing ACCESS cycle raises it
            ack_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_i) begin
                        state_r   <= ST_SETUP;
                        busy_o    <= 1'b1;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        pwrite_o  <= req_wr_i;
                        paddr_o   <= req_addr_i;
                        // reads carry no data and no strobes on the bus
                        pwdata_o  <= req_wr_i ? req_wdata_i : {DW{1'b0}};
                        pstrb_o   <= req_wr_i ? req_strb_i : 4'b0000;
                        pprot_o   <= req_prot_i;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_o <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        state_r   <= ST_IDLE;
                        busy_o    <= 1'b0;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        ack_o     <= 1'b1;
                        err_o     <= pslverr_i;
                        // write responses leave the last read data untouched
                        if (!pwrite_o) begin
                            rdata_o <= prdata_i;
                        end else begin
                            rdata_o <= rdata_o;
                        end
`ifdef APB_MST_TIMEOUT_EN
                    end else if (wait_cnt_r == TO_LAST) begin
                        // limit reached with the slave still stalling
                        state_r   <= ST_IDLE;
                        busy_o    <= 1'b0;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        ack_o     <= 1'b1;
                        err_o     <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_o    <= 1'b0;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc_apb_master.sv
// Directed, table-driven bench for intc_apb_master: a vector table of
// transfers with hand-computed results plus hand-written back-to-back,
// reset-abort and (when APB_MST_TIMEOUT_EN is defined) timeout sequences.
module tb_intc_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, req_wr_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        busy_o, ack_o, err_o;
    logic [31:0] rdata_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic [31:0] prdata_i;
    logic        pready_i, pslverr_i;

    int errors = 0;
    int checks = 0;

    intc_apb_master #(.AW(32), .DW(32), .TO_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
        .busy_o(busy_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue request at cycle 0 and check cycle by cycle through the ack.
    task automatic run_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d idle busy", idx), {31'd0, busy_o}, 32'd0);
        req_i = 1'b1; req_wr_i = v.wr; req_addr_i = v.addr;
        req_wdata_i = v.wdata; req_strb_i = v.strb; req_prot_i = v.prot;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0BAD_0BAD;
        tick();
        // change request fields while busy: must be ignored
        req_i = 1'b0; req_wr_i = ~v.wr; req_addr_i = ~v.addr;
        req_wdata_i = ~v.wdata; req_strb_i = ~v.strb; req_prot_i = ~v.prot;
        chk($sformatf("v%0d setup psel", idx), {31'd0, psel_o}, 32'd1);
        chk($sformatf("v%0d setup penable", idx), {31'd0, penable_o}, 32'd0);
        chk($sformatf("v%0d setup busy", idx), {31'd0, busy_o}, 32'd1);
        chk($sformatf("v%0d setup pprot", idx), {29'd0, pprot_o}, {29'd0, v.prot});
        tick();
        for (int k = 0; k <= v.waits; k++) begin
            chk($sformatf("v%0d acc%0d penable", idx, k), {31'd0, penable_o}, 32'd1);
            chk($sformatf("v%0d acc%0d psel", idx, k), {31'd0, psel_o}, 32'd1);
            chk($sformatf("v%0d acc%0d paddr", idx, k), paddr_o, v.addr);
            chk($sformatf("v%0d acc%0d pwrite", idx, k), {31'd0, pwrite_o}, {31'd0, v.wr});
            chk($sformatf("v%0d acc%0d pwdata", idx, k), pwdata_o, v.exp_pwdata);
            chk($sformatf("v%0d acc%0d pstrb", idx, k), {28'd0, pstrb_o}, {28'd0, v.exp_pstrb});
            chk($sformatf("v%0d acc%0d ack", idx, k), {31'd0, ack_o}, 32'd0);
            if (k == v.waits) begin
                pready_i = 1'b1; pslverr_i = v.slverr; prdata_i = v.prdata;
            end else begin
                // error and data on non-final cycles must not be sampled
                pready_i = 1'b0; pslverr_i = 1'b1; prdata_i = 32'h0BAD_0BAD;
            end
            tick();
        end
        pready_i = 1'b0; pslverr_i = 1'b0;
        chk($sformatf("v%0d ack", idx), {31'd0, ack_o}, 32'd1);
        chk($sformatf("v%0d err", idx), {31'd0, err_o}, {31'd0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), rdata_o, v.exp_rdata);
        chk($sformatf("v%0d ack busy", idx), {31'd0, busy_o}, 32'd0);
        chk($sformatf("v%0d ack psel", idx), {30'd0, psel_o, penable_o}, 32'd0);
        chk($sformatf("v%0d hold paddr", idx), paddr_o, v.addr);
        tick();
        chk($sformatf("v%0d ack strobe", idx), {31'd0, ack_o}, 32'd0);
        chk($sformatf("v%0d rdata hold", idx), rdata_o, v.exp_rdata);
        chk($sformatf("v%0d err hold", idx), {31'd0, err_o}, {31'd0, v.exp_err});
    endtask

    initial begin
        //          wr    addr          wdata         strb   prot  w  prdata        serr  pwdata        pstrb  rdata         err
        vecs[0] = '{1'b0, 32'h0000_0010, 32'hAAAA_5555, 4'hF, 3'd2, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'hF, 3'd1, 3, 32'hFFFF_0000, 1'b0, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0030, 32'h1111_1111, 4'h3, 3'd0, 1, 32'h0000_0042, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0042, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0034, 32'hCAFE_F00D, 4'h5, 3'd7, 0, 32'h7777_7777, 1'b0, 32'hCAFE_F00D, 4'h5, 32'h0000_0042, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0038, 32'h0BEE_F00D, 4'h3, 3'd4, 2, 32'h5555_5555, 1'b1, 32'h0BEE_F00D, 4'h3, 32'h0000_0042, 1'b1};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h2222_2222, 4'hC, 3'd5, 0, 32'h8000_0001, 1'b0, 32'h0000_0000, 4'h0, 32'h8000_0001, 1'b0};

        rst = 1'b1; req_i = 1'b0; req_wr_i = 1'b0; req_addr_i = 32'h0;
        req_wdata_i = 32'h0; req_strb_i = 4'h0; req_prot_i = 3'd0;
        prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;
        tick(); tick();
        chk("reset bus", {psel_o, penable_o, pwrite_o, busy_o, ack_o, err_o, pstrb_o, pprot_o}, 32'd0);
        chk("reset paddr", paddr_o, 32'd0);
        chk("reset rdata", rdata_o, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // back-to-back: req held high, second accepted in the ack cycle
        req_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h0000_0100; req_prot_i = 3'd0;
        tick();                                   // cycle 1 SETUP
        chk("b2b first setup", {31'd0, psel_o}, 32'd1);
        pready_i = 1'b1; prdata_i = 32'hA5A5_0001; pslverr_i = 1'b0;
        tick();                                   // cycle 2 ACCESS
        req_addr_i = 32'h0000_0200;
        tick();                                   // cycle 3 ack, IDLE
        pready_i = 1'b0;
        chk("b2b first ack", {31'd0, ack_o}, 32'd1);
        chk("b2b first rdata", rdata_o, 32'hA5A5_0001);
        chk("b2b ack cycle idle", {30'd0, psel_o, busy_o}, 32'd0);
        tick();                                   // cycle 4 second SETUP
        req_i = 1'b0;
        chk("b2b second setup psel", {31'd0, psel_o}, 32'd1);
        chk("b2b second setup penable", {31'd0, penable_o}, 32'd0);
        chk("b2b second paddr", paddr_o, 32'h0000_0200);
        pready_i = 1'b1; prdata_i = 32'hA5A5_0002;
        tick(); tick();                           // ACCESS, then ack
        pready_i = 1'b0;
        chk("b2b second ack", {31'd0, ack_o}, 32'd1);
        chk("b2b second rdata", rdata_o, 32'hA5A5_0002);
        tick();

        // reset during ACCESS: abandon, no ack
        req_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h0000_0300;
        req_wdata_i = 32'h9999_8888; req_strb_i = 4'hF; req_prot_i = 3'd3;
        tick(); req_i = 1'b0;
        tick();
        chk("rst pre penable", {31'd0, penable_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst outputs", {psel_o, penable_o, pwrite_o, busy_o, ack_o, err_o, pstrb_o, pprot_o}, 32'd0);
        chk("rst paddr/pwdata", paddr_o | pwdata_o | rdata_o, 32'd0);
        pready_i = 1'b1; pslverr_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst no ack %0d", k), {30'd0, ack_o, psel_o}, 32'd0);
        end
        pready_i = 1'b0; pslverr_i = 1'b0;

`ifdef APB_MST_TIMEOUT_EN
        // stalled slave: 4 wait cycles then error ack, rdata unchanged
        req_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h0000_0400;
        tick(); req_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to wait %0d", k), {30'd0, ack_o, penable_o}, 32'd1);
            tick();
        end
        chk("to ack", {31'd0, ack_o}, 32'd1);
        chk("to err", {31'd0, err_o}, 32'd1);
        chk("to rdata", rdata_o, 32'd0);
        tick();
        // pready at the limit cycle wins over the timeout
        req_i = 1'b1; req_addr_i = 32'h0000_0404;
        tick(); req_i = 1'b0;
        tick(); tick(); tick(); tick();
        pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'h1357_2468;
        tick();
        pready_i = 1'b0;
        chk("to limit ack", {31'd0, ack_o}, 32'd1);
        chk("to limit err", {31'd0, err_o}, 32'd0);
        chk("to limit rdata", rdata_o, 32'h1357_2468);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intc_apb_master.md
Name: intc_apb_master

Overview:
- APB requester (initiator) that turns a simple single-outstanding request/acknowledge interface into APB3/APB4 SETUP/ACCESS transfers.
- Used by on-chip initiators (debug/DMA-style agents) to reach register blocks that expose APB slave ports, such as the interrupt controller register slave.
- Handles slave wait states (pready) and error response (pslverr), and returns read data and a one-cycle completion strobe.

Parameters:
- AW, 32, APB address width
- DW, 32, APB data width (32 only; pstrb is 4 bits)
- TO_CYC, 255, ACCESS-phase wait-state limit in cycles (used only with APB_MST_TIMEOUT_EN); range 1..255

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_i  input  1  transfer request from local initiator
- req_wr_i  input  1  1=write, 0=read
- req_addr_i  input  AW  transfer address
- req_wdata_i  input  DW  write data
- req_strb_i  input  4  write byte strobes
- req_prot_i  input  3  protection attributes
- busy_o  output  1  transfer in progress; req_i ignored while high
- ack_o  output  1  one-cycle completion strobe
- rdata_o  output  DW  read data, valid when ack_o=1 for a read
- err_o  output  1  error flag, valid when ack_o=1
- psel_o  output  1  APB select
- penable_o  output  1  APB enable
- pwrite_o  output  1  APB direction
- paddr_o  output  AW  APB address
- pwdata_o  output  DW  APB write data
- pstrb_o  output  4  APB strobes
- pprot_o  output  3  APB protection
- prdata_i  input  DW  APB read data
- pready_i  input  1  APB ready
- pslverr_i  input  1  APB slave error

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- While rst=1, all outputs are 0 and the FSM goes to IDLE on the next clk edge.
- All outputs are registered. The only combinational input path is pready_i, pslverr_i and prdata_i into registers.
- FSM states:
  - IDLE: psel_o=0, penable_o=0, busy_o=0. If req_i=1, latch wr, addr, wdata, strb and prot, then go to SETUP.
  - SETUP: psel_o=1, penable_o=0, busy_o=1. Always go to ACCESS after one cycle.
  - ACCESS: psel_o=1, penable_o=1, busy_o=1.
    - If pready_i=0, stay in ACCESS (wait state).
    - If pready_i=1, capture rdata_o (reads only) and err_o=pslverr_i, set ack_o=1 for the next cycle, and go to IDLE.
- paddr_o, pwrite_o, pprot_o and pstrb_o are held stable from SETUP through the final ACCESS cycle.
- pwdata_o is held stable over the same interval for writes and is driven 0 on reads. pstrb_o is forced to 4'b0000 on reads.
- After a transfer, paddr_o, pwdata_o and the other bus outputs hold their last value. rdata_o and err_o hold until the next ack.
- Latency with zero wait states:
  - Request sampled in IDLE at cycle 0.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - ack_o=1 at cycle 3; N wait states add N cycles.
- Back-to-back transfers:
  - In the ack_o cycle the FSM is already in IDLE with busy_o=0.
  - A req_i=1 in that cycle is accepted, so there is one IDLE cycle between transfers.
- req_i is level-sampled only in IDLE. Changes to req_* while busy_o=1 are ignored.
- A write response carries no data: rdata_o is unchanged on write acks.
- pslverr_i is only sampled in the completing ACCESS cycle.
- Reset mid-transfer: the transfer is abandoned, psel_o and penable_o drop on the next edge, and no ack_o is produced.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on SETUP entry and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TO_CYC while pready_i is still 0, the transfer terminates: FSM goes to IDLE, ack_o=1 and err_o=1 next cycle, and rdata_o is unchanged.
  - pready_i=1 in the same cycle the limit is reached takes priority: normal completion.
- Not defined: no counter logic exists, and ACCESS waits indefinitely for pready_i.

Test Plan:
- Zero-wait read:
  - Stimulus: req_i=1, req_wr_i=0, addr=0x0000_0010, slave returns prdata=0xDEAD_BEEF with pready=1.
  - Required: psel_o at cycle 1, penable_o at cycle 2, pstrb_o=0, pwdata_o=0, ack_o=1 at cycle 3, rdata_o=0xDEAD_BEEF, err_o=0.
- Write with 3 wait states:
  - Stimulus: addr=0x24, wdata=0x1234_5678, strb=0xF, pready low for 3 ACCESS cycles.
  - Required: address, data and strobes stable for 4 ACCESS cycles, ack_o at cycle 6, rdata_o unchanged.
- Slave error:
  - Stimulus: pslverr_i=1 with pready_i=1 on a read.
  - Required: ack_o=1 with err_o=1. The next good transfer then returns err_o=0.
- Back-to-back and reset:
  - Stimulus: req_i held high for two requests.
  - Required: second SETUP starts 1 cycle after the first ack_o (accepted in the ack cycle).
  - Stimulus: rst=1 during a later ACCESS.
  - Required: all outputs 0 next cycle and no ack_o.
- Timeout (macro defined, TO_CYC=4):
  - Stimulus: pready_i held 0.
  - Required: ack_o=1 and err_o=1 after 4 wait cycles.
  - Stimulus: pready_i=1 exactly at the limit.
  - Required: normal completion with err_o=pslverr_i.
- Ignored request changes:
  - Stimulus: change req_addr_i and req_wr_i while busy_o=1.
  - Required: paddr_o and pwrite_o unchanged until ack.
